// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 2;
  localparam int STAT_WIDTH      = 16;

  typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0] req_idx_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan requesters in rotated order starting at ptr and keep the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters,
// with burst locking and one-cycle read-response routing.
// Optional statistics counters are enabled with the SRAM_ARB_STATS_EN macro.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0]                   req_lock,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 mem_cs,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_din,
  input  logic [DATA_WIDTH-1:0]                mem_dout
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]   grant_cnt,
  output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]   stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  lock_state_e          state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   rd_tag_q, rd_tag_d;

  logic [NUM_REQ-1:0]   rr_gnt;
  logic [IDX_W-1:0]     rr_idx;
  logic [NUM_REQ-1:0]   ready;
  logic [NUM_REQ-1:0]   hs;
  logic [IDX_W-1:0]     hs_idx;
  logic                 hs_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Grant selection: a lock owner overrides round-robin; nothing is granted in reset.
  always_comb begin
    ready  = rr_gnt;
    hs_idx = rr_idx;
    if (state_q == ST_LOCKED) begin
      ready          = '0;
      ready[owner_q] = 1'b1;
      hs_idx         = owner_q;
    end
    if (!rst_n) begin
      ready = '0;
    end
  end

  assign req_ready = ready;
  assign hs        = req_valid & ready;
  assign hs_any    = |hs;

  // SRAM pins follow the granted requester; cs only on a real handshake.
  always_comb begin
    mem_cs   = hs_any;
    mem_we   = hs_any & req_we[hs_idx];
    mem_addr = req_addr[hs_idx];
    mem_din  = req_wdata[hs_idx];
  end

  assign rsp_valid = rd_tag_q;
  assign rsp_rdata = mem_dout;

  // Next-state: lock FSM, priority pointer and read-response tag.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    rd_tag_d = '0;
    if (hs_any) begin
      if (!req_we[hs_idx]) begin
        rd_tag_d[hs_idx] = 1'b1;
      end
      if (req_lock[hs_idx]) begin
        state_d = ST_LOCKED;
        owner_d = hs_idx;
      end else begin
        state_d = ST_UNLOCKED;
        ptr_d   = IDX_W'((int'(hs_idx) + 1) % NUM_REQ);
      end
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_UNLOCKED;
      owner_q  <= '0;
      ptr_q    <= '0;
      rd_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      rd_tag_q <= rd_tag_d;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_WIDTH-1:0] grant_cnt_q, grant_cnt_d;
  logic [NUM_REQ-1:0][STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Per-requester saturating handshake and stall counters.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        grant_cnt_d[i] = sat_inc(grant_cnt_q[i]);
      end
      if (req_valid[i] && !ready[i]) begin
        stall_cnt_d[i] = sat_inc(stall_cnt_q[i]);
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
